// File: rtl/rle_encoder.sv
// Binary-pixel run-length encoder: emits (sym, len, last) run words into a DEPTH-entry FIFO.
// A word is visible one cycle after its push. pix_ready is low unless the FIFO has at least two free entries.
module rle_encoder #(
    parameter int DEPTH = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        pix_in,
    input  logic        pix_valid,
    input  logic        sol,
    input  logic        eol,
    output logic        pix_ready,
    output logic [10:0] run_len,
    output logic        run_sym,
    output logic        run_last,
    output logic        run_valid,
    input  logic        run_ready,
    output logic        err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [10:0] LEN_MAX = 11'd2047;

    typedef struct packed {
        logic        sym;
        logic [10:0] len;
        logic        last;
    } run_word_t;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_nxt;
    logic          cur_sym, sym_nxt;
    logic [10:0]   run_cnt, run_nxt;
    logic [10:0]   line_cnt, line_nxt;
    logic          err_set, close;
    logic          push_a, push_b;
    run_word_t     word_a, word_b, head;

    run_word_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          ready_en;
    logic          accept, pop;

    assign pix_ready = ready_en && (count <= CW'(DEPTH - 2));
    assign accept    = pix_valid && pix_ready;
    assign run_valid = (count != '0);
    assign pop       = run_valid && run_ready;
    assign head      = run_valid ? mem[rd_ptr] : '0;
    assign run_sym   = head.sym;
    assign run_len   = head.len;
    assign run_last  = head.last;

    always_comb begin
        state_nxt = state;
        sym_nxt   = cur_sym;
        run_nxt   = run_cnt;
        line_nxt  = line_cnt;
        err_set   = 1'b0;
        close     = 1'b0;
        push_a    = 1'b0;
        push_b    = 1'b0;
        word_a    = '0;
        word_b    = '0;
        if (accept) begin
            if (sol) begin
                // A line always opens with a symbol-0 run, possibly empty.
                err_set   = (state == RUN);
                state_nxt = RUN;
                sym_nxt   = pix_in;
                run_nxt   = 11'd1;
                line_nxt  = 11'd1;
                push_a    = pix_in;
                close     = eol;
            end else if (state == RUN) begin
                if (line_cnt == LEN_MAX) begin
                    err_set = !eol;
                    close   = eol;
                end else begin
                    line_nxt = line_cnt + 11'd1;
                    if (pix_in == cur_sym) begin
                        run_nxt = run_cnt + 11'd1;
                    end else begin
                        push_a      = 1'b1;
                        word_a.sym  = cur_sym;
                        word_a.len  = run_cnt;
                        sym_nxt     = pix_in;
                        run_nxt     = 11'd1;
                    end
                    close = eol;
                end
            end
            if (close) begin
                state_nxt = IDLE;
                if (push_a) begin
                    push_b      = 1'b1;
                    word_b.sym  = sym_nxt;
                    word_b.len  = run_nxt;
                    word_b.last = 1'b1;
                end else begin
                    push_a      = 1'b1;
                    word_a.sym  = sym_nxt;
                    word_a.len  = run_nxt;
                    word_a.last = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            cur_sym  <= 1'b0;
            run_cnt  <= '0;
            line_cnt <= '0;
            err      <= 1'b0;
            ready_en <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            state    <= state_nxt;
            cur_sym  <= sym_nxt;
            run_cnt  <= run_nxt;
            line_cnt <= line_nxt;
            err      <= err | err_set;
            ready_en <= 1'b1;
            wr_ptr   <= wr_ptr + AW'(push_a) + AW'(push_b);
            rd_ptr   <= rd_ptr + AW'(pop);
            count    <= count + CW'(push_a) + CW'(push_b) - CW'(pop);
        end
    end

    // The two-free-entry admission rule keeps pushes clear of the head slot.
    always_ff @(posedge CLK) begin
        if (push_a) mem[wr_ptr] <= word_a;
        if (push_b) mem[wr_ptr + AW'(1)] <= word_b;
    end

endmodule

// File: tb/tb_rle_encoder.sv
// Directed bench for rle_encoder: inputs driven 1 time unit after CLK rise, popped words logged on CLK fall.
module tb_rle_encoder;
    localparam int DEPTH = 8;

    logic        CLK = 1'b0;
    logic        RST, pix_in, pix_valid, sol, eol, run_ready;
    logic        pix_ready, run_sym, run_last, run_valid, err;
    logic [10:0] run_len;

    int          checks = 0;
    int          errors = 0;
    logic [12:0] got [$];

    rle_encoder #(.DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .pix_in(pix_in), .pix_valid(pix_valid),
        .sol(sol), .eol(eol), .pix_ready(pix_ready), .run_len(run_len),
        .run_sym(run_sym), .run_last(run_last), .run_valid(run_valid),
        .run_ready(run_ready), .err(err)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (run_valid && run_ready) got.push_back({run_sym, run_len, run_last});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic send_beat(input logic p, input logic s, input logic e);
        int t = 0;
        pix_in = p; sol = s; eol = e; pix_valid = 1'b1;
        while (!pix_ready && t < 200) begin
            @(posedge CLK); #1; t++;
        end
        if (!pix_ready) begin
            checks++; errors++;
            $display("FAIL beat_accept: pix_ready=%0b after %0d cycles, required 1", pix_ready, t);
        end else begin
            @(posedge CLK); #1;
        end
        pix_valid = 1'b0; sol = 1'b0; eol = 1'b0;
    endtask

    task automatic wait_words(input int n, output bit ok);
        int t = 0;
        while (got.size() < n && t < 5000) begin
            @(posedge CLK); #1; t++;
        end
        repeat (5) begin @(posedge CLK); #1; end
        ok = (got.size() == n);
    endtask

    task automatic pulse_reset();
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; pix_in = 1'b0; pix_valid = 1'b0; sol = 1'b0; eol = 1'b0; run_ready = 1'b0;
        repeat (2) begin @(posedge CLK); #1; end
        checks++;
        if ({run_valid, run_sym, run_len, run_last, err, pix_ready} !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%0b sym=%0b len=%0d last=%0b err=%0b rdy=%0b, required all 0",
                     run_valid, run_sym, run_len, run_last, err, pix_ready);
        end
        RST = 1'b0;
        #1;
        checks++;
        if (pix_ready !== 1'b0) begin
            errors++; $display("FAIL ready_before_edge: pix_ready=%0b, required 0", pix_ready);
        end
        @(posedge CLK); #1;
        checks++;
        if (pix_ready !== 1'b1) begin
            errors++; $display("FAIL ready_after_edge: pix_ready=%0b, required 1", pix_ready);
        end
    endtask

    task automatic test_basic_line();
        logic [12:0] exp [$];
        bit ok;
        run_ready = 1'b1;
        got.delete();
        for (int i = 0; i < 640; i++)
            send_beat((i >= 100 && i < 300), (i == 0), (i == 639));
        exp.push_back({1'b0, 11'd100, 1'b0});
        exp.push_back({1'b1, 11'd200, 1'b0});
        exp.push_back({1'b0, 11'd340, 1'b1});
        wait_words(exp.size(), ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_count: got %0d words, required %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            logic [12:0] g;
            g = (i < got.size()) ? got[i] : 'x;
            checks++;
            if (g !== exp[i]) begin
                errors++;
                $display("FAIL basic_word%0d: got %0b/%0d/%0b, required %0b/%0d/%0b",
                         i, g[12], g[11:1], g[0], exp[i][12], exp[i][11:1], exp[i][0]);
            end
        end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL basic_err: err=%0b, required 0", err); end
    endtask

    task automatic test_leading_one();
        logic [12:0] exp [$];
        bit ok;
        run_ready = 1'b1;
        got.delete();
        send_beat(1'b1, 1'b0, 1'b0);
        send_beat(1'b0, 1'b0, 1'b1);
        send_beat(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            send_beat((i < 5), (i == 0), (i == 7));
        exp.push_back({1'b0, 11'd0, 1'b0});
        exp.push_back({1'b1, 11'd5, 1'b0});
        exp.push_back({1'b0, 11'd3, 1'b1});
        wait_words(exp.size(), ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL lead1_count: got %0d words, required %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            logic [12:0] g;
            g = (i < got.size()) ? got[i] : 'x;
            checks++;
            if (g !== exp[i]) begin
                errors++;
                $display("FAIL lead1_word%0d: got %0b/%0d/%0b, required %0b/%0d/%0b",
                         i, g[12], g[11:1], g[0], exp[i][12], exp[i][11:1], exp[i][0]);
            end
        end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL idle_discard_err: err=%0b, required 0", err); end
    endtask

    task automatic test_single_beat();
        bit ok;
        run_ready = 1'b0;
        got.delete();
        send_beat(1'b1, 1'b1, 1'b1);
        checks++;
        if ({run_valid, run_sym, run_len, run_last} !== {1'b1, 1'b0, 11'd0, 1'b0}) begin
            errors++;
            $display("FAIL single_head: valid=%0b %0b/%0d/%0b, required 1 0/0/0", run_valid, run_sym, run_len, run_last);
        end
        repeat (3) begin @(posedge CLK); #1; end
        checks++;
        if ({run_valid, run_sym, run_len, run_last} !== {1'b1, 1'b0, 11'd0, 1'b0}) begin
            errors++;
            $display("FAIL single_stall: valid=%0b %0b/%0d/%0b, required 1 0/0/0", run_valid, run_sym, run_len, run_last);
        end
        run_ready = 1'b1;
        wait_words(2, ok);
        checks++;
        if (!ok || got[0] !== {1'b0, 11'd0, 1'b0} || got[1] !== {1'b1, 11'd1, 1'b1}) begin
            errors++;
            $display("FAIL single_words: got %0d words first=%h second=%h, required 2 words 0000 1003",
                     got.size(), (got.size() > 0) ? got[0] : 13'h0, (got.size() > 1) ? got[1] : 13'h0);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        run_ready = 1'b0;
        got.delete();
        for (int i = 0; i < 7; i++) send_beat(i[0], (i == 0), 1'b0);
        checks++;
        if (pix_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_at6: pix_ready=%0b, required 1", pix_ready); end
        send_beat(1'b1, 1'b0, 1'b0);
        checks++;
        if (pix_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_at7: pix_ready=%0b, required 0", pix_ready); end
        fork
            begin
                repeat (4) begin @(posedge CLK); #1; end
                checks++;
                if (pix_ready !== 1'b0 || got.size() != 0 ||
                    {run_valid, run_sym, run_len, run_last} !== {1'b1, 1'b0, 11'd1, 1'b0}) begin
                    errors++;
                    $display("FAIL bp_stall: rdy=%0b popped=%0d head=%0b %0b/%0d/%0b, required 0 0 1 0/1/0",
                             pix_ready, got.size(), run_valid, run_sym, run_len, run_last);
                end
                run_ready = 1'b1;
            end
            send_beat(1'b0, 1'b0, 1'b0);
        join
        send_beat(1'b1, 1'b0, 1'b1);
        wait_words(10, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_count: got %0d words, required 10", got.size()); end
        for (int k = 0; k < 10; k++) begin
            logic [12:0] g, e;
            g = (k < got.size()) ? got[k] : 'x;
            e = {k[0], 11'd1, (k == 9)};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL bp_word%0d: got %0b/%0d/%0b, required %0b/%0d/%0b",
                         k, g[12], g[11:1], g[0], e[12], e[11:1], e[0]);
            end
        end
    endtask

    task automatic test_mid_sol();
        bit ok;
        run_ready = 1'b1;
        got.delete();
        for (int i = 0; i < 49; i++) send_beat(1'b0, (i == 0), 1'b0);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL midsol_err_before: err=%0b, required 0", err); end
        send_beat(1'b0, 1'b1, 1'b0);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL midsol_err_after: err=%0b, required 1", err); end
        for (int j = 1; j <= 6; j++) send_beat((j >= 4), 1'b0, (j == 6));
        wait_words(2, ok);
        checks++;
        if (!ok || got[0] !== {1'b0, 11'd4, 1'b0} || got[1] !== {1'b1, 11'd3, 1'b1}) begin
            errors++;
            $display("FAIL midsol_words: got %0d words first=%h second=%h, required 2 words 0008 1007",
                     got.size(), (got.size() > 0) ? got[0] : 13'h0, (got.size() > 1) ? got[1] : 13'h0);
        end
    endtask

    task automatic test_long_line();
        bit ok;
        pulse_reset();
        run_ready = 1'b1;
        got.delete();
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL long_err_cleared: err=%0b, required 0", err); end
        for (int i = 0; i < 2047; i++) send_beat(1'b0, (i == 0), 1'b0);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL long_err_at2047: err=%0b, required 0", err); end
        send_beat(1'b0, 1'b0, 1'b0);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL long_err_at2048: err=%0b, required 1", err); end
        send_beat(1'b0, 1'b0, 1'b1);
        wait_words(1, ok);
        checks++;
        if (!ok || got[0] !== {1'b0, 11'd2047, 1'b1}) begin
            errors++;
            $display("FAIL long_word: got %0d words first=%h, required 1 word 0fff",
                     got.size(), (got.size() > 0) ? got[0] : 13'h0);
        end
    endtask

    task automatic test_reset_flush();
        bit ok;
        run_ready = 1'b0;
        got.delete();
        send_beat(1'b0, 1'b1, 1'b0);
        send_beat(1'b1, 1'b0, 1'b0);
        send_beat(1'b0, 1'b0, 1'b0);
        send_beat(1'b1, 1'b0, 1'b0);
        checks++;
        if (run_valid !== 1'b1 || err !== 1'b1) begin
            errors++; $display("FAIL flush_pre: valid=%0b err=%0b, required 1 1", run_valid, err);
        end
        RST = 1'b1;
        #1;
        checks++;
        if (run_valid !== 1'b0 || err !== 1'b0 || pix_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_reset: valid=%0b err=%0b rdy=%0b, required 0 0 0", run_valid, err, pix_ready);
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        run_ready = 1'b1;
        send_beat(1'b1, 1'b1, 1'b0);
        send_beat(1'b1, 1'b0, 1'b1);
        wait_words(2, ok);
        checks++;
        if (!ok || got[0] !== {1'b0, 11'd0, 1'b0} || got[1] !== {1'b1, 11'd2, 1'b1}) begin
            errors++;
            $display("FAIL flush_words: got %0d words first=%h second=%h, required 2 words 0000 1005",
                     got.size(), (got.size() > 0) ? got[0] : 13'h0, (got.size() > 1) ? got[1] : 13'h0);
        end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL flush_err: err=%0b, required 0", err); end
    endtask

    initial begin
        test_reset();
        test_basic_line();
        test_leading_one();
        test_single_beat();
        test_back_to_back();
        test_mid_sol();
        test_long_line();
        test_reset_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
